// File: rtl/cpu_types_pkg.sv
// Shared types for the memory arbiter: RAM status codes, grant FSM states and the word type.
package cpu_types_pkg;

  localparam int WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    IGNT = 2'd1,
    DGNT = 2'd2
  } arb_state_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the instruction, data and RAM-side signals around the memory arbiter.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32
);
  import cpu_types_pkg::*;

  logic              iREN;
  logic [ADDR_W-1:0] iaddr;
  logic              iwait;
  logic [ADDR_W-1:0] iload;
  logic              dREN;
  logic              dWEN;
  logic [ADDR_W-1:0] daddr;
  logic [ADDR_W-1:0] dstore;
  logic              dwait;
  logic [ADDR_W-1:0] dload;
  logic              err;
  logic              ramREN;
  logic              ramWEN;
  logic [ADDR_W-1:0] ramaddr;
  logic [ADDR_W-1:0] ramstore;
  logic [ADDR_W-1:0] ramload;
  ramstate_t         ramstate;

  // slave: the arbiter itself; master: datapath requesters plus the RAM
  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output iwait, iload, dwait, dload, err, ramREN, ramWEN, ramaddr, ramstore
  );

  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    input  iwait, iload, dwait, dload, err, ramREN, ramWEN, ramaddr, ramstore
  );

endinterface

// File: rtl/mem_arb_timer.sv
// Grant watchdog: counts non-completing grant cycles and flags the last permitted one.
module mem_arb_timer #(
  parameter int TIMEOUT = 255
) (
  input  logic CLK,
  input  logic nRST,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] LAST = TW'(TIMEOUT - 1);

  logic [TW-1:0] count;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

  assign expire = (count == LAST);

endmodule

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter: data requests win, a starvation counter forces instruction
// fetch progress, and a watchdog aborts grants the RAM never answers.
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 255
) (
  input  logic         CLK,
  input  logic         nRST,
  mem_arbiter_if.slave bus
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  arb_state_t        state, next_state;
  logic [SW-1:0]     starve, starve_next;
  logic              data_req;
  logic              ifetch_forced;
  logic              owner_req;
  logic              done;
  logic              failed;
  logic              expire;
  logic              timer_clr;
  logic              timer_en;
  logic [ADDR_W-1:0] hit_load;

  assign data_req      = bus.dREN | bus.dWEN;
  assign ifetch_forced = bus.iREN && (starve == STARVE_MAX);
  assign hit_load      = (bus.ramstate == ACCESS) ? bus.ramload : '0;

  mem_arb_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .CLK    (CLK),
    .nRST   (nRST),
    .clear  (timer_clr),
    .enable (timer_en),
    .expire (expire)
  );

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state  <= IDLE;
      starve <= '0;
    end else begin
      state  <= next_state;
      starve <= starve_next;
    end
  end

  always_comb begin
    next_state   = state;
    starve_next  = starve;
    owner_req    = 1'b0;
    done         = 1'b0;
    failed       = 1'b0;
    timer_clr    = 1'b0;
    timer_en     = 1'b0;
    bus.iwait    = 1'b1;
    bus.dwait    = 1'b1;
    bus.iload    = '0;
    bus.dload    = '0;
    bus.err      = 1'b0;
    bus.ramREN   = 1'b0;
    bus.ramWEN   = 1'b0;
    bus.ramaddr  = '0;
    bus.ramstore = '0;

    case (state)
      IDLE: begin
        timer_clr = 1'b1;
        if (data_req && !ifetch_forced) begin
          next_state = DGNT;
          if (bus.iREN && (starve != STARVE_MAX)) starve_next = starve + 1'b1;
        end else if (bus.iREN) begin
          next_state  = IGNT;
          starve_next = '0;
        end
      end
      DGNT: begin
        owner_req    = data_req;
        bus.ramREN   = bus.dREN;
        bus.ramWEN   = bus.dWEN;
        bus.ramaddr  = bus.daddr;
        bus.ramstore = bus.dstore;
      end
      IGNT: begin
        owner_req   = bus.iREN;
        bus.ramREN  = bus.iREN;
        bus.ramaddr = bus.iaddr;
      end
      default: next_state = IDLE;
    endcase

    // A dropped request ends the grant silently; otherwise ACCESS/ERROR/expiry completes it
    if (state != IDLE) begin
      done     = owner_req && ((bus.ramstate == ACCESS) || (bus.ramstate == ERROR) || expire);
      failed   = done && (bus.ramstate != ACCESS);
      timer_en = owner_req && !done;
      if (!owner_req || done) next_state = IDLE;
      if (done) begin
        bus.err = failed;
        if (state == DGNT) begin
          bus.dwait = 1'b0;
          bus.dload = hit_load;
        end else begin
          bus.iwait = 1'b0;
          bus.iload = hit_load;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboarded bench for mem_arbiter: directed latency/corner cases plus randomized rounds
// whose completion order and data come from a transaction-level arbitration/memory model.
module tb_mem_arbiter;
  import cpu_types_pkg::*;

  localparam int SL = 4;
  localparam int TO = 8;

  typedef struct packed {
    logic        is_d;
    logic        err;
    logic        chk_load;
    logic [31:0] load;
  } exp_t;

  typedef struct packed {
    int        lat;
    ramstate_t fin;
  } plan_t;

  logic CLK = 1'b0;
  logic nRST;

  mem_arbiter_if #(.ADDR_W(32)) bus ();

  mem_arbiter #(.ADDR_W(32), .STARVE_LIMIT(SL), .TIMEOUT(TO)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus)
  );

  always #5 CLK = ~CLK;

  int          checks = 0;
  int          errors = 0;
  exp_t        exp_q[$];
  plan_t       plan_q[$];
  logic [31:0] ref_mem[logic [31:0]];
  logic [31:0] ram_mem[logic [31:0]];
  int          m_starve = 0;
  bit          auto_ram = 1'b0;
  ramstate_t   man_state = FREE;
  logic [31:0] man_load = 32'd0;
  bit          d_wr_a[8];
  logic [31:0] d_addr_a[8];
  logic [31:0] d_data_a[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  task automatic cyc();
    @(posedge CLK); #1;
  endtask

  task automatic mid();
    @(negedge CLK); #1;
  endtask

  task automatic push_exp(input logic is_d, input logic e, input logic cl, input logic [31:0] ld);
    exp_t x;
    x.is_d = is_d; x.err = e; x.chk_load = cl; x.load = ld;
    exp_q.push_back(x);
  endtask

  // RAM stand-in: scripted status in directed tests, planned latency/outcome otherwise
  bit    in_grant = 1'b0;
  int    gk = 0;
  plan_t cur_plan;
  always @(negedge CLK) begin
    if (!auto_ram) begin
      bus.ramstate = man_state;
      bus.ramload  = man_load;
      in_grant     = 1'b0;
    end else if (bus.ramREN || bus.ramWEN) begin
      if (!in_grant) begin
        in_grant = 1'b1;
        gk = 0;
        if (plan_q.size() > 0) cur_plan = plan_q.pop_front();
        else begin cur_plan.lat = 0; cur_plan.fin = ACCESS; end
      end else gk++;
      bus.ramload = $urandom;
      if (gk < cur_plan.lat) bus.ramstate = BUSY;
      else begin
        bus.ramstate = cur_plan.fin;
        if (cur_plan.fin == ACCESS) begin
          if (bus.ramWEN) ram_mem[bus.ramaddr] = bus.ramstore;
          else bus.ramload = ram_mem.exists(bus.ramaddr) ? ram_mem[bus.ramaddr] : 32'd0;
        end
      end
    end else begin
      in_grant     = 1'b0;
      bus.ramstate = FREE;
      bus.ramload  = $urandom;
    end
  end

  exp_t mon_e;
  always begin
    @(negedge CLK); #1;
    if (nRST) begin
      if (!bus.iwait || !bus.dwait) begin
        chk("single owner", 32'(!bus.iwait && !bus.dwait), 32'd0);
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected completion: iwait=%0b dwait=%0b, expected none", bus.iwait, bus.dwait);
        end else begin
          mon_e = exp_q.pop_front();
          chk("owner is data", 32'(!bus.dwait), 32'(mon_e.is_d));
          chk("completion err", 32'(bus.err), 32'(mon_e.err));
          if (mon_e.chk_load) chk("load word", bus.dwait ? bus.iload : bus.dload, mon_e.load);
        end
      end else begin
        chk("err without completion", 32'(bus.err), 32'd0);
      end
    end
  end

  task automatic wait_done(input bit is_d);
    for (int c = 0; c < 100; c++) begin
      mid();
      if (is_d ? !bus.dwait : !bus.iwait) return;
    end
    checks++; errors++;
    $display("FAIL %s request completion: none within 100 cycles, expected one", is_d ? "data" : "fetch");
  endtask

  task automatic drive_i(input bit on, input logic [31:0] a);
    if (!on) return;
    cyc();
    bus.iREN = 1'b1; bus.iaddr = a;
    wait_done(1'b0);
    cyc();
    bus.iREN = 1'b0;
  endtask

  task automatic drive_d(input int n);
    if (n == 0) return;
    cyc();
    for (int j = 0; j < n; j++) begin
      bus.dREN = !d_wr_a[j]; bus.dWEN = d_wr_a[j];
      bus.daddr = d_addr_a[j]; bus.dstore = d_data_a[j];
      wait_done(1'b1);
      cyc();
    end
    bus.dREN = 1'b0; bus.dWEN = 1'b0;
  endtask

  // Transaction-level outcome of one granted access: planned RAM answer and resulting data
  task automatic model_access(input bit is_d, input bit wr, input logic [31:0] a, input logic [31:0] wd);
    plan_t p;
    int r;
    bit e;
    r = $urandom_range(0, 15);
    p.lat = $urandom_range(0, 3);
    p.fin = (r >= 1 && r < 3) ? ERROR : ACCESS;
    if (r == 0) p.lat = 20;
    e = (r < 3);
    plan_q.push_back(p);
    push_exp(is_d, e, !(wr && !e), e ? 32'd0 : (ref_mem.exists(a) ? ref_mem[a] : 32'd0));
    if (wr && !e) ref_mem[a] = wd;
  endtask

  task automatic run_round(input bit i_on, input int n);
    logic [31:0] ia;
    int di;
    bit ipend;
    ia = 32'($urandom_range(0, 15)) << 2;
    for (int j = 0; j < n; j++) begin
      d_wr_a[j]   = 1'($urandom_range(0, 1));
      d_addr_a[j] = 32'($urandom_range(0, 15)) << 2;
      d_data_a[j] = $urandom;
    end
    di = 0;
    ipend = i_on;
    while (ipend || di < n) begin
      if (di < n && !(ipend && m_starve == SL)) begin
        if (ipend && m_starve < SL) m_starve++;
        model_access(1'b1, d_wr_a[di], d_addr_a[di], d_data_a[di]);
        di++;
      end else begin
        m_starve = 0;
        model_access(1'b0, 1'b0, ia, 32'd0);
        ipend = 1'b0;
      end
    end
    fork
      drive_i(i_on, ia);
      drive_d(n);
    join
    repeat ($urandom_range(1, 3)) cyc();
  endtask

  initial begin
    nRST = 1'b0;
    bus.iREN = 1'b0; bus.iaddr = '0; bus.dREN = 1'b0; bus.dWEN = 1'b0;
    bus.daddr = '0; bus.dstore = '0;
    repeat (2) @(posedge CLK);
    mid();
    chk("reset iwait", 32'(bus.iwait), 32'd1);
    chk("reset dwait", 32'(bus.dwait), 32'd1);
    chk("reset err", 32'(bus.err), 32'd0);
    chk("reset ramREN", 32'(bus.ramREN), 32'd0);
    chk("reset ramWEN", 32'(bus.ramWEN), 32'd0);
    chk("reset ramaddr", bus.ramaddr, 32'd0);
    chk("reset ramstore", bus.ramstore, 32'd0);
    chk("reset iload", bus.iload, 32'd0);
    chk("reset dload", bus.dload, 32'd0);
    chk("reset state", 32'(dut.state), 32'(IDLE));
    chk("reset starve", 32'(dut.starve), 32'd0);
    cyc(); nRST = 1'b1;
    cyc();

    // Lone fetch: BUSY, BUSY, then ACCESS
    man_load = 32'hDEADBEEF;
    push_exp(1'b0, 1'b0, 1'b1, 32'hDEADBEEF);
    for (int k = 0; k < 5; k++) begin
      cyc();
      bus.iREN = (k < 4); bus.iaddr = 32'h40;
      man_state = (k == 0 || k == 4) ? FREE : ((k == 3) ? ACCESS : BUSY);
      mid();
      chk("fetch ramREN", 32'(bus.ramREN), 32'(k >= 1 && k <= 3));
      chk("fetch iwait", 32'(bus.iwait), 32'(k != 3));
      chk("fetch dwait", 32'(bus.dwait), 32'd1);
      if (k >= 1 && k <= 3) chk("fetch ramaddr", bus.ramaddr, 32'h40);
    end

    // Contention: data write wins, fetch follows after one idle cycle
    man_state = ACCESS; man_load = 32'h12345678;
    push_exp(1'b1, 1'b0, 1'b0, 32'd0);
    push_exp(1'b0, 1'b0, 1'b1, 32'h12345678);
    cyc();
    bus.iREN = 1'b1; bus.iaddr = 32'h80; bus.dWEN = 1'b1; bus.daddr = 32'h100; bus.dstore = 32'h5;
    mid();
    chk("cont c0 ramWEN", 32'(bus.ramWEN), 32'd0);
    cyc(); mid();
    chk("cont c1 ramWEN", 32'(bus.ramWEN), 32'd1);
    chk("cont c1 ramaddr", bus.ramaddr, 32'h100);
    chk("cont c1 ramstore", bus.ramstore, 32'h5);
    chk("cont c1 dwait", 32'(bus.dwait), 32'd0);
    cyc(); bus.dWEN = 1'b0; mid();
    chk("cont c2 ramREN", 32'(bus.ramREN), 32'd0);
    chk("cont c2 ramWEN", 32'(bus.ramWEN), 32'd0);
    cyc(); mid();
    chk("cont c3 ramREN", 32'(bus.ramREN), 32'd1);
    chk("cont c3 ramaddr", bus.ramaddr, 32'h80);
    chk("cont c3 iwait", 32'(bus.iwait), 32'd0);
    cyc(); bus.iREN = 1'b0; mid();
    chk("cont c4 ramREN", 32'(bus.ramREN), 32'd0);

    // Timeout: RAM stuck BUSY, grant completes with err on the TO-th grant cycle
    man_state = BUSY;
    push_exp(1'b1, 1'b1, 1'b1, 32'd0);
    for (int k = 0; k < 10; k++) begin
      cyc();
      bus.dREN = (k < 9); bus.daddr = 32'h200;
      mid();
      chk("timeout dwait", 32'(bus.dwait), 32'(k != TO));
      chk("timeout ramREN", 32'(bus.ramREN), 32'(k >= 1 && k <= TO));
    end

    // ERROR response on the first grant cycle
    man_load = 32'hFFFFFFFF;
    push_exp(1'b0, 1'b1, 1'b1, 32'd0);
    cyc(); man_state = FREE; bus.iREN = 1'b1; bus.iaddr = 32'h44; mid();
    cyc(); man_state = ERROR; mid();
    chk("error iwait", 32'(bus.iwait), 32'd0);
    cyc(); man_state = FREE; bus.iREN = 1'b0; mid();
    chk("error then idle", 32'(bus.ramREN), 32'd0);

    // Abort: request dropped in the second grant cycle even though RAM answers
    cyc(); man_state = BUSY; bus.dREN = 1'b1; bus.daddr = 32'h300; mid();
    cyc(); mid();
    chk("abort c1 ramREN", 32'(bus.ramREN), 32'd1);
    cyc(); bus.dREN = 1'b0; man_state = ACCESS; mid();
    chk("abort ramREN", 32'(bus.ramREN), 32'd0);
    chk("abort dwait", 32'(bus.dwait), 32'd1);
    cyc(); man_state = FREE; mid();
    chk("abort state", 32'(dut.state), 32'(IDLE));

    // Reset asserted in the middle of an instruction grant
    cyc(); man_state = BUSY; bus.iREN = 1'b1; bus.iaddr = 32'h48; mid();
    cyc(); mid();
    chk("rst c1 ramREN", 32'(bus.ramREN), 32'd1);
    cyc(); nRST = 1'b0; mid();
    chk("rst ramREN", 32'(bus.ramREN), 32'd0);
    chk("rst ramaddr", bus.ramaddr, 32'd0);
    chk("rst iwait", 32'(bus.iwait), 32'd1);
    chk("rst err", 32'(bus.err), 32'd0);
    chk("rst iload", bus.iload, 32'd0);
    chk("rst state", 32'(dut.state), 32'(IDLE));
    cyc(); bus.iREN = 1'b0; man_state = FREE; nRST = 1'b1; mid();
    chk("rst release iwait", 32'(bus.iwait), 32'd1);
    cyc();

    // Starvation burst, then randomized rounds against the model
    auto_ram = 1'b1;
    cyc();
    run_round(1'b1, 5);
    chk("starve after burst", 32'(dut.starve), 32'(m_starve));
    for (int r = 0; r < 40; r++) begin
      bit ion;
      int nd;
      ion = 1'($urandom_range(0, 1));
      nd = $urandom_range(0, 5);
      if (!ion && nd == 0) ion = 1'b1;
      run_round(ion, nd);
    end
    chk("starve at end", 32'(dut.starve), 32'(m_starve));
    repeat (3) cyc();
    chk("expected queue drained", 32'(exp_q.size()), 32'd0);
    chk("plan queue drained", 32'(plan_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global watchdog: simulation still running at %0t, expected finish", $time);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single-ported RAM between the instruction fetch path and the data access path of the pipelined datapath.
- Sequences every access through a registered grant FSM:
  - data requests have priority;
  - a starvation counter guarantees instruction fetch progress;
  - a timeout watchdog bounds a hung RAM access.
- Produces the per-requester wait/load signals that the datapath turns into ihit/dhit.

Parameters:
- ADDR_W, 32, address and data width in bits.
- STARVE_LIMIT, 4, number of consecutive data grants won while an instruction request is pending before the instruction request is forced to win.
- TIMEOUT, 255, cycles a grant may wait for RAM ACCESS before it is aborted with an error.

Ports:
- CLK  in  1  clock, rising edge.
- nRST  in  1  asynchronous active-low reset.
- iREN  in  1  instruction read request; held high until iwait drops.
- iaddr  in  ADDR_W  instruction byte address.
- iwait  out  1  low for exactly the completion cycle of an instruction read.
- iload  out  ADDR_W  instruction word; valid only when iwait is low.
- dREN  in  1  data read request.
- dWEN  in  1  data write request. dREN and dWEN are never high together.
- daddr  in  ADDR_W  data byte address.
- dstore  in  ADDR_W  write data.
- dwait  out  1  low for exactly the completion cycle of a data access.
- dload  out  ADDR_W  data read word; valid only when dwait is low.
- err  out  1  one-cycle pulse coincident with a completion that ended in RAM ERROR or timeout.
- ramREN  out  1  RAM read enable.
- ramWEN  out  1  RAM write enable.
- ramaddr  out  ADDR_W  RAM address.
- ramstore  out  ADDR_W  RAM write data.
- ramload  in  ADDR_W  RAM read data.
- ramstate  in  2  RAM status: FREE=0, BUSY=1, ACCESS=2, ERROR=3.

Behaviour:
- Reset (async, nRST low) values:
  - state=IDLE, starve=0, timer=0;
  - iwait=1, dwait=1, err=0;
  - ramREN=0, ramWEN=0, ramaddr=0, ramstore=0;
  - iload=0, dload=0.
- FSM states are IDLE, IGNT and DGNT.
- IDLE:
  - RAM outputs are deasserted.
  - If (dREN|dWEN) and not (iREN and starve==STARVE_LIMIT), go to DGNT.
  - Otherwise, if iREN, go to IGNT.
  - Otherwise, stay in IDLE.
- DGNT:
  - ramREN=dREN, ramWEN=dWEN, ramaddr=daddr, ramstore=dstore, all combinational from inputs.
- IGNT:
  - ramREN=1, ramWEN=0, ramaddr=iaddr, ramstore=0.
- Completion happens in any grant cycle where ramstate is ACCESS or ERROR, or where timer==TIMEOUT-1.
  - The owning wait output drops that same cycle (combinational).
  - The owning load output equals ramload on ACCESS; it is 0 on ERROR or timeout.
  - err=1 on ERROR or timeout.
  - The next state is IDLE.
- Latency:
  - A request seen in IDLE at cycle 0 is granted at cycle 1.
  - The earliest completion is cycle 1, giving a 2-cycle minimum.
  - There is always at least one IDLE cycle between grants.
- Timer:
  - Clears on entering a grant.
  - Increments each non-completing grant cycle.
- Starvation counter:
  - Increments (saturating at STARVE_LIMIT) when IDLE issues a data grant while iREN=1.
  - Clears to 0 when an instruction grant is issued.
  - Otherwise it holds.
- Abort: if the granted requester drops its request mid-grant (DGNT with dREN=dWEN=0, or IGNT with iREN=0):
  - RAM enables drop that cycle;
  - no wait pulse and no err;
  - next state is IDLE.
- Same-cycle arrival: iREN and a data request rising together in IDLE resolve to DGNT unless the starvation counter is saturated.
- Requests arriving during a grant are only sampled in IDLE.
- The non-owner wait output stays 1 throughout.
- Asserting nRST mid-grant returns immediately to the reset state. No completion pulse is generated.

Decomposition:
- The shared package cpu_types_pkg holds:
  - ramstate_t (FREE/BUSY/ACCESS/ERROR);
  - arb_state_t (IDLE/IGNT/DGNT);
  - word_t.
- Sub-module mem_arb_timer holds the timeout counter:
  - inputs: clear, enable;
  - output: expire;
  - parameterised by TIMEOUT.
- The FSM, starvation counter and output muxing stay in mem_arbiter.

Test Plan:
- Lone fetch:
  - Stimulus: iREN=1, iaddr=0x40; ramstate goes BUSY for 2 cycles then ACCESS with ramload=0xDEADBEEF.
  - Required: iwait low for exactly one cycle (cycle 3 after request) with iload=0xDEADBEEF; ramREN high cycles 1-3 with ramaddr=0x40; dwait=1 throughout.
- Contention:
  - Stimulus: iREN and dWEN rise together; daddr=0x100, dstore=0x5; RAM ACCESS immediately.
  - Required: DGNT first (ramWEN=1, ramaddr=0x100, ramstore=0x5, dwait low cycle 1); IDLE at cycle 2; IGNT at cycle 3; iwait low at cycle 3.
- Starvation:
  - Stimulus: iREN held high while dREN is continuously re-asserted.
  - Required: data wins 4 grants; 5th grant goes to instruction; starve counter reads 0 afterward.
- Timeout:
  - Stimulus: TIMEOUT=8; dREN=1; ramstate stuck at BUSY.
  - Required: dwait low and err=1 on the 8th grant cycle; dload=0; returns to IDLE.
- ERROR response:
  - Stimulus: iREN=1; ramstate=ERROR in the first grant cycle.
  - Required: iwait low, err=1, iload=0 that cycle.
- Abort and reset:
  - Stimulus: drop dREN in the second DGNT cycle; separately, pulse nRST low mid-IGNT.
  - Required: no wait pulse, RAM enables deasserted the same cycle; after reset all outputs are at reset values and state is IDLE.
